// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC select, misalign/trap capture,
// mret return and a circular return-address stack for the predictor.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   advance           current instruction retires (gates all updates)
//   compressed        current instruction is 16-bit
//   pc_mode           00 INC, 01 BRCH, 10 JREG, 11 JIMM
//   flag              branch taken condition (BRCH)
//   reg_direct        rs1 value (JREG)
//   imm_offset        sign-extended offset (BRCH/JIMM)
//   trap_req/cause    trap request and its cause code
//   mret              return from trap
//   ras_push/ras_pop  call / return hints
//   pc_out            registered PC
//   link_out          pc_out + 2/4
//   epc_out/cause_out saved exception PC and cause
//   misalign          this advance takes a misaligned-target trap
//   ras_top/valid     predicted return address / stack non-empty
module pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter bit              C_EXT        = 1'b1,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            compressed,
    input  logic [1:0]      pc_mode,
    input  logic            flag,
    input  logic [XLEN-1:0] reg_direct,
    input  logic [XLEN-1:0] imm_offset,
    input  logic            trap_req,
    input  logic [3:0]      trap_cause,
    input  logic            mret,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] link_out,
    output logic [XLEN-1:0] epc_out,
    output logic [3:0]      cause_out,
    output logic            misalign,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_valid
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] epc;
    logic [3:0]      cause;
    logic [XLEN-1:0] inc;
    logic [XLEN-1:0] target;
    logic            checked;
    logic            odd;
    logic            ras_en;
    logic            ras_wr;
    logic [PW-1:0]   ras_wa;
    logic [PW-1:0]   wp;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] mem [RAS_DEPTH];

    assign inc      = compressed ? XLEN'(2) : XLEN'(4);
    assign link_out = pc + inc;

    // checked marks targets that leave the sequential stream
    always_comb begin
        target  = pc + inc;
        checked = 1'b0;
        case (pc_mode)
            2'b00: begin
                target  = pc + inc;
                checked = 1'b0;
            end
            2'b01: begin
                target  = pc + (flag ? imm_offset : inc);
                checked = flag;
            end
            2'b10: begin
                target  = {reg_direct[XLEN-1:1], 1'b0};
                checked = 1'b1;
            end
            2'b11: begin
                target  = pc + imm_offset;
                checked = 1'b1;
            end
            default: begin
                target  = pc + inc;
                checked = 1'b0;
            end
        endcase
    end

    assign odd = C_EXT ? target[0] : (|target[1:0]);

    assign misalign = advance && !trap_req
                    && checked && odd;

    // stack moves only when the instruction really retires
    assign ras_en = advance && !trap_req && !misalign;
    assign ras_wr = ras_en && ras_push;

    // push+pop on a non-empty stack replaces the top in place
    assign ras_wa = (ras_pop && cnt != '0)
                  ? wp - PW'(1) : wp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_VECTOR;
            epc   <= '0;
            cause <= '0;
            wp    <= '0;
            cnt   <= '0;
        end else if (advance) begin
            if (trap_req) begin
                epc   <= pc;
                cause <= trap_cause;
                pc    <= TRAP_VECTOR;
            end else if (misalign) begin
                epc   <= pc;
                cause <= 4'd0;
                pc    <= TRAP_VECTOR;
            end else begin
                pc <= mret ? epc : target;
                if (ras_push && !(ras_pop && cnt != '0)) begin
                    wp <= wp + PW'(1);
                    if (cnt != FULL)
                        cnt <= cnt + CW'(1);
                end else if (ras_pop && !ras_push
                             && cnt != '0) begin
                    wp  <= wp - PW'(1);
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ras_wr)
            mem[ras_wa] <= link_out;
    end

    assign pc_out    = pc;
    assign epc_out   = epc;
    assign cause_out = cause;
    assign ras_top   = mem[wp - PW'(1)];
    assign ras_valid = (cnt != '0);

endmodule
